// File: rtl/datapath.sv
// datapath: 32-bit single-bus CPU datapath. Sixteen GPRs, PC, IR, MAR, MDR,
// Y, 64-bit Z, HI and LO share one combinational bus. An external sequencer
// drives the out/in strobes; every register transfer takes one clock edge.
// The ALU takes A from Y and B from the bus, and Z captures its 64-bit result.

// One general-purpose register. It loads from the bus when its enable is set.
module gpr_cell (
  input  logic        Clock,
  input  logic        clear,
  input  logic        ld,
  input  logic [31:0] d,
  output logic [31:0] q
);
  // Load on enable. Clear is asynchronous and active-low.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear)  q <= '0;
    else if (ld) q <= d;
  end
endmodule

module datapath (
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] Mdatain,
  input  logic        Read,
  input  logic        IncPC,
  input  logic [15:0] Rin,
  input  logic [15:0] Rout,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        Zin,
  input  logic        MDRin,
  input  logic        MARin,
  input  logic        Yin,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        PCout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        MDRout,
  input  logic        Cout,
  input  logic [4:0]  opcode,
  output logic [31:0] BusMuxOut,
  output logic [31:0] MARq,
  output logic [31:0] IRq
);
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic [15:0][31:0] r_q;
  logic [31:0]       pc_q, mdr_q, y_q, hi_q, lo_q;
  logic [63:0]       z_q;
  logic [31:0]       c_sext;

  logic [63:0]       alu_res;
  logic [63:0]       prod;
  logic [31:0]       quo, rem;
  logic [63:0]       rot_r, rot_l;
  logic [4:0]        sh;

  // Register file: one cell per GPR. All cells load from the shared bus.
  genvar g;
  generate
    for (g = 0; g < 16; g++) begin : g_gpr
      gpr_cell u_gpr (
        .Clock (Clock),
        .clear (clear),
        .ld    (Rin[g]),
        .d     (BusMuxOut),
        .q     (r_q[g])
      );
    end
  endgenerate

  assign c_sext = {{13{IRq[18]}}, IRq[18:0]};

  // Bus source select. Lower-priority sources are assigned first, so a later
  // assignment from a higher-priority source wins. R0 has the highest priority.
  always_comb begin
    BusMuxOut = '0;
    if (Cout)     BusMuxOut = c_sext;
    if (MDRout)   BusMuxOut = mdr_q;
    if (PCout)    BusMuxOut = pc_q;
    if (Zlowout)  BusMuxOut = z_q[31:0];
    if (Zhighout) BusMuxOut = z_q[63:32];
    if (LOout)    BusMuxOut = lo_q;
    if (HIout)    BusMuxOut = hi_q;
    for (int i = 15; i >= 0; i--)
      if (Rout[i]) BusMuxOut = r_q[i];
  end

  // Signed product. Both operands are sign-extended, so the low 64 bits of
  // the product are the exact 64-bit signed result.
  assign prod = {{32{y_q[31]}}, y_q} * {{32{BusMuxOut[31]}}, BusMuxOut};

  // Rotates shift a doubled copy of A, so a shift amount of 0 needs no special case.
  assign sh    = BusMuxOut[4:0];
  assign rot_r = {y_q, y_q} >> sh;
  assign rot_l = {y_q, y_q} << sh;

  // Signed divide. Divide-by-zero and the single overflow case
  // (-2^31 / -1) are handled explicitly, so the result never depends on the tool.
  always_comb begin
    quo = '0;
    rem = '0;
    if (BusMuxOut == 32'd0) begin
      quo = 32'hFFFF_FFFF;
      rem = y_q;
    end else if (y_q == 32'h8000_0000 && BusMuxOut == 32'hFFFF_FFFF) begin
      quo = 32'h8000_0000;
      rem = '0;
    end else begin
      quo = $signed(y_q) / $signed(BusMuxOut);
      rem = $signed(y_q) % $signed(BusMuxOut);
    end
  end

  // ALU result mux. IncPC overrides the opcode. A result that defines only
  // 32 bits leaves the upper half of Z at zero.
  always_comb begin
    alu_res = '0;
    if (IncPC) begin
      alu_res[31:0] = BusMuxOut + 32'd1;
    end else begin
      case (opcode)
        OP_ADD, OP_ADDI: alu_res[31:0] = y_q + BusMuxOut;
        OP_SUB:          alu_res[31:0] = y_q - BusMuxOut;
        OP_AND, OP_ANDI: alu_res[31:0] = y_q & BusMuxOut;
        OP_OR,  OP_ORI:  alu_res[31:0] = y_q | BusMuxOut;
        OP_SHR:          alu_res[31:0] = y_q >> sh;
        OP_SHRA:         alu_res[31:0] = $signed(y_q) >>> sh;
        OP_SHL:          alu_res[31:0] = y_q << sh;
        OP_ROR:          alu_res[31:0] = rot_r[31:0];
        OP_ROL:          alu_res[31:0] = rot_l[63:32];
        OP_MUL:          alu_res       = prod;
        OP_DIV:          alu_res       = {rem, quo};
        OP_NEG:          alu_res[31:0] = -BusMuxOut;
        OP_NOT:          alu_res[31:0] = ~BusMuxOut;
        default:         alu_res       = '0;
      endcase
    end
  end

  // Special-purpose registers. MDR chooses between memory data and the bus.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      pc_q  <= '0;
      IRq   <= '0;
      MARq  <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      if (PCin)  pc_q  <= BusMuxOut;
      if (IRin)  IRq   <= BusMuxOut;
      if (MARin) MARq  <= BusMuxOut;
      if (MDRin) mdr_q <= Read ? Mdatain : BusMuxOut;
      if (Yin)   y_q   <= BusMuxOut;
      if (Zin)   z_q   <= alu_res;
      if (HIin)  hi_q  <= BusMuxOut;
      if (LOin)  lo_q  <= BusMuxOut;
    end
  end

endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed transfers on the datapath, checked against a
// register-level behavioural model and against hand-computed values.
module tb_datapath;
  logic        Clock = 1'b0;
  logic        clear;
  logic [31:0] Mdatain;
  logic        Read, IncPC;
  logic [15:0] Rin, Rout;
  logic        PCin, IRin, Zin, MDRin, MARin, Yin, HIin, LOin;
  logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout;
  logic [4:0]  opcode;
  logic [31:0] BusMuxOut, MARq, IRq;

  datapath dut (
    .Clock(Clock), .clear(clear), .Mdatain(Mdatain), .Read(Read), .IncPC(IncPC),
    .Rin(Rin), .Rout(Rout), .PCin(PCin), .IRin(IRin), .Zin(Zin), .MDRin(MDRin),
    .MARin(MARin), .Yin(Yin), .HIin(HIin), .LOin(LOin), .PCout(PCout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout),
    .MDRout(MDRout), .Cout(Cout), .opcode(opcode), .BusMuxOut(BusMuxOut),
    .MARq(MARq), .IRq(IRq)
  );

  always #5 Clock = ~Clock;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Model state
  logic [31:0] m_r [16];
  logic [31:0] m_pc, m_ir, m_mar, m_mdr, m_y, m_hi, m_lo;
  logic [63:0] m_z;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    foreach (m_r[i]) m_r[i] = '0;
    m_pc = '0; m_ir = '0; m_mar = '0; m_mdr = '0; m_y = '0; m_hi = '0; m_lo = '0; m_z = '0;
  endtask

  // The bus takes the first active source in priority order.
  function automatic logic [31:0] m_bus();
    logic [31:0] c;
    c = {{13{m_ir[18]}}, m_ir[18:0]};
    for (int i = 0; i < 16; i++) if (Rout[i]) return m_r[i];
    if (HIout)    return m_hi;
    if (LOout)    return m_lo;
    if (Zhighout) return m_z[63:32];
    if (Zlowout)  return m_z[31:0];
    if (PCout)    return m_pc;
    if (MDRout)   return m_mdr;
    if (Cout)     return c;
    return 32'd0;
  endfunction

  function automatic logic [63:0] m_alu(input logic [31:0] a, input logic [31:0] b,
                                        input logic [4:0] op, input logic inc);
    int ia, ib, s;
    longint la, lb, q, r, p;
    ia = a; ib = b; la = ia; lb = ib; s = int'(b[4:0]);
    if (inc) return {32'd0, b + 32'd1};
    case (op)
      5'd3, 5'd12: return {32'd0, a + b};
      5'd4:        return {32'd0, a - b};
      5'd5, 5'd13: return {32'd0, a & b};
      5'd6, 5'd14: return {32'd0, a | b};
      5'd7:        return {32'd0, a >> s};
      5'd8:        begin ia = ia >>> s; return {32'd0, 32'(ia)}; end
      5'd9:        return {32'd0, a << s};
      5'd10:       return {32'd0, (s == 0) ? a : ((a >> s) | (a << (32 - s)))};
      5'd11:       return {32'd0, (s == 0) ? a : ((a << s) | (a >> (32 - s)))};
      5'd15:       begin p = la * lb; return p; end
      5'd16: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = la / lb; r = la % lb;
        return {r[31:0], q[31:0]};
      end
      5'd17:       return {32'd0, -b};
      5'd18:       return {32'd0, ~b};
      default:     return 64'd0;
    endcase
  endfunction

  // Apply one transfer to the model, using the strobes present at the edge.
  task automatic m_commit();
    logic [31:0] b;
    logic [63:0] z;
    b = m_bus();
    z = m_alu(m_y, b, opcode, IncPC);
    for (int i = 0; i < 16; i++) if (Rin[i]) m_r[i] = b;
    if (PCin)  m_pc  = b;
    if (IRin)  m_ir  = b;
    if (MARin) m_mar = b;
    if (MDRin) m_mdr = Read ? Mdatain : b;
    if (Yin)   m_y   = b;
    if (HIin)  m_hi  = b;
    if (LOin)  m_lo  = b;
    if (Zin)   m_z   = z;
  endtask

  // Every negedge: the bus and the visible registers must match the model.
  always @(negedge Clock) begin
    if (chk_en) begin
      check("cyc bus", BusMuxOut, m_bus());
      check("cyc MARq", MARq, m_mar);
      check("cyc IRq", IRq, m_ir);
    end
  end

  task automatic idle();
    Mdatain = '0; Read = 0; IncPC = 0; Rin = '0; Rout = '0;
    PCin = 0; IRin = 0; Zin = 0; MDRin = 0; MARin = 0; Yin = 0; HIin = 0; LOin = 0;
    PCout = 0; Zhighout = 0; Zlowout = 0; HIout = 0; LOout = 0; MDRout = 0; Cout = 0;
    opcode = '0;
  endtask

  task automatic tick();
    @(posedge Clock);
    m_commit();
    #1;
    idle();
  endtask

  task automatic expect_bus(input string name, input logic [31:0] exp);
    #1;
    check(name, BusMuxOut, exp);
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; Read = 1; MDRin = 1; tick();
  endtask

  task automatic set_y(input logic [31:0] v);
    load_mdr(v); MDRout = 1; Yin = 1; tick();
  endtask

  task automatic alu_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
    set_y(a); load_mdr(b); MDRout = 1; opcode = op; Zin = 1; tick();
  endtask

  task automatic mdr_to_reg(input logic [31:0] v, input int idx);
    load_mdr(v); MDRout = 1; Rin[idx] = 1; tick();
  endtask

  initial begin
    idle();
    clear = 0;
    m_reset();
    #2;
    check("reset bus", BusMuxOut, 32'd0);
    check("reset MARq", MARq, 32'd0);
    check("reset IRq", IRq, 32'd0);
    #10;
    clear = 1;
    chk_en = 1;

    // Memory data into GPRs through MDR.
    mdr_to_reg(32'h12, 4);
    mdr_to_reg(32'h14, 5);
    mdr_to_reg(32'h18, 0);
    Rout[4] = 1; expect_bus("R4 value", 32'h12); tick();

    // Add: R0 = R4 + R5
    Rout[4] = 1; Yin = 1; tick();
    Rout[5] = 1; opcode = 5'b00011; Zin = 1; tick();
    Zlowout = 1; Rin[0] = 1; expect_bus("add Zlow", 32'h26); tick();
    Rout[0] = 1; expect_bus("R0 after add", 32'h26); tick();
    Zhighout = 1; expect_bus("add Zhigh", 32'h0); tick();

    // PC increment. MAR captures the old PC in the same edge.
    PCout = 1; MARin = 1; IncPC = 1; Zin = 1; opcode = 5'b01111; tick();
    #1; check("MARq from PC", MARq, 32'h0);
    Zlowout = 1; PCin = 1; expect_bus("IncPC Zlow", 32'h1); tick();
    PCout = 1; expect_bus("PC after inc", 32'h1); tick();
    Zhighout = 1; expect_bus("IncPC Zhigh", 32'h0); tick();

    // IR load and sign-extended constant.
    load_mdr(32'h2891_8000);
    MDRout = 1; IRin = 1; tick();
    #1; check("IRq", IRq, 32'h2891_8000);
    Cout = 1; expect_bus("C sext pos", 32'h0001_8000); tick();
    load_mdr(32'h0004_0001);
    MDRout = 1; IRin = 1; tick();
    Cout = 1; expect_bus("C sext neg", 32'hFFFC_0001); tick();

    // Multiply and divide.
    alu_op(32'hFFFF_FFFE, 32'd3, 5'b01111);
    Zhighout = 1; expect_bus("mul hi", 32'hFFFF_FFFF); tick();
    Zlowout = 1; expect_bus("mul lo", 32'hFFFF_FFFA); tick();
    alu_op(32'd7, 32'hFFFF_FFFE, 5'b10000);
    Zlowout = 1; expect_bus("div quo", 32'hFFFF_FFFD); tick();
    Zhighout = 1; expect_bus("div rem", 32'h1); tick();
    alu_op(32'd7, 32'd0, 5'b10000);
    Zlowout = 1; expect_bus("div0 lo", 32'hFFFF_FFFF); tick();
    Zhighout = 1; expect_bus("div0 hi", 32'h7); tick();

    // Sweep all opcodes with A=0x80012345 and B=4. Both halves of Z are read back.
    for (int op = 0; op < 32; op++) begin
      alu_op(32'h8001_2345, 32'd4, 5'(op));
      Zlowout = 1;
      case (op)
        4:  expect_bus("sub", 32'h8001_2341);
        7:  expect_bus("shr", 32'h0800_1234);
        8:  expect_bus("shra", 32'hF800_1234);
        9:  expect_bus("shl", 32'h0012_3450);
        10: expect_bus("ror", 32'h5800_1234);
        11: expect_bus("rol", 32'h0012_3458);
        12: expect_bus("addi", 32'h8001_2349);
        17: expect_bus("neg", 32'hFFFF_FFFC);
        18: expect_bus("not", 32'hFFFF_FFFB);
        31: expect_bus("bad op", 32'h0);
        default: ;
      endcase
      tick();
      Zhighout = 1; tick();
    end
    alu_op(32'h1234_5678, 32'd0, 5'b01011);
    Zlowout = 1; expect_bus("rol by 0", 32'h1234_5678); tick();

    // HI/LO, then source priority.
    mdr_to_reg(32'hABCD_0000, 0);
    Rout[0] = 1; HIin = 1; tick();
    mdr_to_reg(32'h0000_5555, 0);
    Rout[0] = 1; LOin = 1; tick();
    HIout = 1; LOout = 1; PCout = 1; expect_bus("prio HI", 32'hABCD_0000); tick();
    LOout = 1; MDRout = 1; expect_bus("prio LO", 32'h0000_5555); tick();
    Rout[4] = 1; Rout[5] = 1; expect_bus("prio R4", 32'h12); tick();
    Rout[5] = 1; Rout[15] = 1; HIout = 1; expect_bus("prio R5", 32'h14); tick();

    // Register read and written in the same cycle: the old value drives the bus.
    Rout[5] = 1; Yin = 1; tick();
    Rout[5] = 1; opcode = 5'b00011; Zin = 1; tick();
    Zlowout = 1; Rin[5] = 1; tick();
    Rout[5] = 1; Rin[5] = 1; Yin = 1; expect_bus("R5 rw", 32'h28); tick();

    // Asynchronous clear between edges, with MARq loaded beforehand.
    Rout[4] = 1; MARin = 1; tick();
    Rout[4] = 1;
    #1;
    clear = 0;
    m_reset();
    #1;
    check("clr bus", BusMuxOut, 32'h0);
    check("clr MARq", MARq, 32'h0);
    check("clr IRq", IRq, 32'h0);
    #1;
    clear = 1;
    tick();
    HIout = 1; expect_bus("HI after clr", 32'h0); tick();
    mdr_to_reg(32'h77, 3);
    Rout[3] = 1; expect_bus("load after clr", 32'h77); tick();

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
